// File: rtl/field_collision_check.sv
// Sequential collision checker: walks the 16 cells of a latched 4x4 piece, one per
// cycle, and reports whether any occupied cell leaves the field or overlaps the stack.
module field_collision_check #(
    parameter int FIELD_W    = 20,
    parameter int FIELD_H    = 20,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [4:0]                 block_pos_x,
    input  logic [4:0]                 block_pos_y,
    input  logic [1:0]                 rotate,
    input  logic [15:0]                block_matrix,
    input  logic [FIELD_W*FIELD_H-1:0] field_background,
    output logic                       busy,
    output logic                       done,
    output logic                       collide,
    output logic                       collide_wall,
    output logic                       collide_stack
);

    localparam int         NBITS = FIELD_W * FIELD_H;
    localparam int         IDX_W = $clog2(NBITS);
    localparam logic [5:0] FW    = 6'(FIELD_W);
    localparam logic [5:0] FH    = 6'(FIELD_H);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [4:0]         px_q, px_d;
    logic [4:0]         py_q, py_d;
    logic [1:0]         rot_q, rot_d;
    logic [15:0]        mat_q, mat_d;
    logic [NBITS-1:0]   fld_q, fld_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               wall_q, wall_d;
    logic               stack_q, stack_d;

    logic [1:0]         bx, by;
    logic [3:0]         mat_idx;
    logic               cell_on;
    logic [5:0]         fx, fy;
    logic               in_field;
    logic [IDX_W-1:0]   fld_idx;
    logic               hit_wall, hit_stack;

    assign bx = cnt_q[1:0];
    assign by = cnt_q[3:2];

    // For a 2-bit value, 3-v is simply its bitwise complement.
    always_comb begin
        mat_idx = {by, bx};
        unique case (rot_q)
            2'd0: mat_idx = {by, bx};
            2'd1: mat_idx = {~bx, by};
            2'd2: mat_idx = {~by, ~bx};
            2'd3: mat_idx = {bx, ~by};
            default: mat_idx = {by, bx};
        endcase
    end

    assign cell_on  = mat_q[mat_idx];
    assign fx       = {1'b0, px_q} + {4'd0, bx};
    assign fy       = {1'b0, py_q} + {4'd0, by};
    assign in_field = (fx < FW) && (fy < FH);
    assign fld_idx  = IDX_W'(fy) * IDX_W'(FIELD_W) + IDX_W'(fx);

    // The field is only looked up for in-range cells; out-of-range cells are walls.
    assign hit_wall  = cell_on && !in_field;
    assign hit_stack = cell_on && in_field && fld_q[fld_idx];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        px_d    = px_q;
        py_d    = py_q;
        rot_d   = rot_q;
        mat_d   = mat_q;
        fld_d   = fld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        wall_d  = wall_q;
        stack_d = stack_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    px_d    = block_pos_x;
                    py_d    = block_pos_y;
                    rot_d   = rotate;
                    mat_d   = block_matrix;
                    fld_d   = field_background;
                    cnt_d   = 4'd0;
                    wall_d  = 1'b0;
                    stack_d = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                wall_d  = wall_q | hit_wall;
                stack_d = stack_q | hit_stack;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'd15 || (EARLY_EXIT && (hit_wall || hit_stack))) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                cnt_d   = 4'd0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            px_q    <= 5'd0;
            py_q    <= 5'd0;
            rot_q   <= 2'd0;
            mat_q   <= 16'd0;
            fld_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wall_q  <= 1'b0;
            stack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            px_q    <= px_d;
            py_q    <= py_d;
            rot_q   <= rot_d;
            mat_q   <= mat_d;
            fld_q   <= fld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wall_q  <= wall_d;
            stack_q <= stack_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign collide_wall  = wall_q;
    assign collide_stack = stack_q;
    assign collide       = wall_q | stack_q;

endmodule

// File: tb/tb_field_collision_check.sv
// Randomized bench for field_collision_check: a full-scan and an early-exit instance
// share stimulus and are compared against a geometric rotate-and-overlay model.
module tb_field_collision_check;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [4:0]   pos_x = '0, pos_y = '0;
    logic [1:0]   rot = '0;
    logic [15:0]  mat = '0;
    logic [399:0] fld = '0;
    logic busy, done, collide, cwall, cstack;
    logic busy_e, done_e, collide_e, cwall_e, cstack_e;

    int   checks = 0, errors = 0;
    int   lat0, bc0, lat1;
    logic w0, s0, c0, w1, s1, c1;
    logic mw, ms, mew, mes;
    int   mfirst;

    always #5 clk = ~clk;

    field_collision_check u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .block_pos_x(pos_x), .block_pos_y(pos_y), .rotate(rot),
        .block_matrix(mat), .field_background(fld),
        .busy(busy), .done(done), .collide(collide),
        .collide_wall(cwall), .collide_stack(cstack)
    );

    field_collision_check #(.EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start(start),
        .block_pos_x(pos_x), .block_pos_y(pos_y), .rotate(rot),
        .block_matrix(mat), .field_background(fld),
        .busy(busy_e), .done(done_e), .collide(collide_e),
        .collide_wall(cwall_e), .collide_stack(cstack_e)
    );

    // Rotate the 4x4 shape clockwise rt times, then overlay it on the field.
    function automatic void model(input int px, input int py, input int rt,
                                  input logic [15:0] m, input logic [399:0] f,
                                  output logic w, output logic s,
                                  output logic ew, output logic es, output int first);
        int g[4][4];
        int t[4][4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) g[r][c] = int'(m[r*4+c]);
        for (int n = 0; n < rt; n++) begin
            t = g;
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 4; x++) g[y][x] = t[3-x][y];
        end
        w = 0; s = 0; ew = 0; es = 0; first = -1;
        for (int k = 0; k < 16; k++) begin
            int x, y, gx, gy;
            logic hw, hs;
            x = k % 4; y = k / 4; gx = px + x; gy = py + y; hw = 0; hs = 0;
            if (g[y][x] != 0) begin
                if (gx >= 20 || gy >= 20) hw = 1;
                else if (f[gy*20+gx]) hs = 1;
            end
            w = w | hw; s = s | hs;
            if ((hw || hs) && first < 0) begin first = k; ew = hw; es = hs; end
        end
    endfunction

    task automatic drain();
        int n = 0;
        while ((busy || busy_e || done || done_e) && n < 100) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int px, input int py, input int rt, input logic [15:0] m);
        bit g0, g1;
        drain();
        pos_x = 5'(px); pos_y = 5'(py); rot = 2'(rt); mat = m; start = 1'b1;
        model(px, py, rt, m, fld, mw, ms, mew, mes, mfirst);
        @(negedge clk);
        start = 1'b0;
        g0 = 0; g1 = 0; lat0 = -1; lat1 = -1; bc0 = 0;
        w0 = 0; s0 = 0; c0 = 0; w1 = 0; s1 = 0; c1 = 0;
        for (int c = 1; c <= 40 && !(g0 && g1); c++) begin
            if (busy) bc0++;
            if (done && !g0) begin g0 = 1; lat0 = c; w0 = cwall; s0 = cstack; c0 = collide; end
            if (done_e && !g1) begin g1 = 1; lat1 = c; w1 = cwall_e; s1 = cstack_e; c1 = collide_e; end
            if (!(g0 && g1)) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, collide, cwall, cstack} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b exp 00000", {busy, done, collide, cwall, cstack});
        end
        checks++;
        if ({busy_e, done_e, collide_e} !== 3'b0) begin
            errors++; $display("FAIL reset_outputs_ee got %b exp 000", {busy_e, done_e, collide_e});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fld = '0;
        run(8, 0, 0, 16'h00F0);
        checks++;
        if (lat0 !== 17) begin errors++; $display("FAIL basic_latency got %0d exp 17", lat0); end
        checks++;
        if (bc0 !== 16) begin errors++; $display("FAIL basic_busy_cycles got %0d exp 16", bc0); end
        checks++;
        if ({w0, s0, c0} !== 3'b000) begin errors++; $display("FAIL basic_flags got %b exp 000", {w0, s0, c0}); end
        run(17, 0, 0, 16'h00F0);
        checks++;
        if ({w0, s0, c0} !== 3'b101) begin errors++; $display("FAIL wall_right got %b exp 101", {w0, s0, c0}); end
        @(negedge clk);
        checks++;
        if ({done, cwall, collide} !== 3'b011) begin
            errors++; $display("FAIL flags_hold got %b exp 011", {done, cwall, collide});
        end
        run(0, 19, 1, 16'h00F0);
        checks++;
        if ({w0, s0, c0} !== 3'b101) begin errors++; $display("FAIL wall_floor_rot1 got %b exp 101", {w0, s0, c0}); end
    endtask

    task automatic test_stack();
        fld = '0;
        fld[5*20+9] = 1'b1;
        run(8, 4, 0, 16'h0660);
        checks++;
        if ({w0, s0, c0} !== 3'b011) begin errors++; $display("FAIL stack_hit got %b exp 011", {w0, s0, c0}); end
        checks++;
        if (lat1 !== 7 || c1 !== 1'b1) begin
            errors++; $display("FAIL stack_hit_ee got lat %0d col %b exp lat 7 col 1", lat1, c1);
        end
        run(10, 4, 0, 16'h0660);
        checks++;
        if ({w0, s0, c0} !== 3'b000) begin errors++; $display("FAIL stack_miss got %b exp 000", {w0, s0, c0}); end
    endtask

    task automatic test_rotation();
        for (int rt = 0; rt < 4; rt++) begin
            int hits = 0;
            for (int k = 0; k < 16; k++) begin
                fld = '0;
                fld[(8 + k/4)*20 + 8 + k%4] = 1'b1;
                run(8, 8, rt, 16'h0072);
                hits += int'(s0);
                checks++;
                if ({w0, s0} !== {mw, ms}) begin
                    errors++; $display("FAIL rot%0d_cell%0d got %b exp %b", rt, k, {w0, s0}, {mw, ms});
                end
            end
            checks++;
            if (hits !== 4) begin errors++; $display("FAIL rot%0d_footprint got %0d exp 4", rt, hits); end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int px, py, rt;
            logic [15:0] m;
            for (int i = 0; i < 400; i++) fld[i] = ($urandom_range(0, 3) == 0);
            px = $urandom_range(0, 22); py = $urandom_range(0, 22); rt = $urandom_range(0, 3);
            m = 16'($urandom);
            run(px, py, rt, m);
            checks++;
            if ({lat0, w0, s0, c0} !== {32'd17, mw, ms, mw | ms}) begin
                errors++; $display("FAIL rand%0d got lat %0d %b exp lat 17 %b", t, lat0, {w0, s0}, {mw, ms});
            end
            checks++;
            if (mfirst >= 0) begin
                if ({lat1, w1, s1, c1} !== {mfirst + 2, mew, mes, 1'b1}) begin
                    errors++; $display("FAIL rand%0d_ee got lat %0d %b exp lat %0d %b", t, lat1, {w1, s1}, mfirst + 2, {mew, mes});
                end
            end else if ({lat1, c1} !== {32'd17, 1'b0}) begin
                errors++; $display("FAIL rand%0d_ee got lat %0d col %b exp lat 17 col 0", t, lat1, c1);
            end
        end
    endtask

    task automatic test_midscan();
        int ndone = 0, nbusy = 0, d = -1;
        logic [2:0] fl = '0;
        drain();
        fld = '0; pos_x = 5'd8; pos_y = 5'd0; rot = 2'd0; mat = 16'h00F0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fld = '1; pos_x = 5'd18; mat = 16'hFFFF; rot = 2'd3;
        for (int c = 1; c <= 45; c++) begin
            if (busy) nbusy++;
            if (done) begin ndone++; if (d < 0) begin d = c; fl = {cwall, cstack, collide}; end end
            start = (c == 5);
            @(negedge clk);
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || nbusy !== 16) begin
            errors++; $display("FAIL midscan_single got done %0d busy %0d exp done 1 busy 16", ndone, nbusy);
        end
        checks++;
        if (d !== 17 || fl !== 3'b000) begin
            errors++; $display("FAIL midscan_latched got lat %0d flags %b exp lat 17 flags 000", d, fl);
        end
    endtask

    task automatic test_start_held();
        int d = -1;
        logic b1 = 1'b1, b2 = 1'b0;
        drain();
        fld = '0; pos_x = 5'd8; pos_y = 5'd0; rot = 2'd0; mat = 16'h00F0; start = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done && d < 0) d = c;
            if (d > 0 && c == d + 1) b1 = busy;
            if (d > 0 && c == d + 2) b2 = busy;
        end
        start = 1'b0;
        checks++;
        if (d !== 17 || b1 !== 1'b0 || b2 !== 1'b1) begin
            errors++; $display("FAIL start_held got lat %0d busy %b%b exp lat 17 busy 01", d, b1, b2);
        end
        drain();
    endtask

    task automatic test_reset_midscan();
        logic pre;
        bit spurious = 0;
        drain();
        fld = '0; pos_x = 5'd19; pos_y = 5'd0; rot = 2'd0; mat = 16'h00F0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        pre = cwall;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pre, busy, done, collide, cwall, cstack} !== 6'b100000) begin
            errors++; $display("FAIL reset_midscan got %b exp 100000", {pre, busy, done, collide, cwall, cstack});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy || done) spurious = 1;
        end
        checks++;
        if (spurious) begin errors++; $display("FAIL reset_no_done got activity exp none"); end
    endtask

    task automatic test_early_exit();
        fld = '0;
        fld[3*20+4] = 1'b1;
        run(3, 3, 0, 16'h0002);
        checks++;
        if (lat1 !== 3 || c1 !== 1'b1) begin
            errors++; $display("FAIL ee_k1 got lat %0d col %b exp lat 3 col 1", lat1, c1);
        end
        checks++;
        if (lat0 !== 17 || c0 !== 1'b1) begin
            errors++; $display("FAIL full_k1 got lat %0d col %b exp lat 17 col 1", lat0, c0);
        end
        run(31, 31, 0, 16'h0000);
        checks++;
        if ({lat0, lat1, c0, c1} !== {32'd17, 32'd17, 2'b00}) begin
            errors++; $display("FAIL empty_matrix got lat %0d/%0d col %b%b exp 17/17 00", lat0, lat1, c0, c1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stack();
        test_rotation();
        test_random();
        test_midscan();
        test_start_held();
        test_reset_midscan();
        test_early_exit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
